// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the multi-cycle controller and the iterative multiplier.
// The controller drives the master side; the multiplier implements the slave side.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_long;
  logic             is_signed;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;
  logic [1:0]       mul_state;

  modport master (
    output start, is_long, is_signed, src_a, src_b,
    input  busy, done, result_lo, result_hi, flag_n, flag_z, mul_state
  );

  modport slave (
    input  start, is_long, is_signed, src_a, src_b,
    output busy, done, result_lo, result_hi, flag_n, flag_z, mul_state
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add multiplier for MUL/UMULL/SMULL: one partial product per cycle,
// SMULL handled by multiplying magnitudes and negating the 64-bit result.
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic reset,
  mul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic               neg_reg;
  logic               long_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic               n_reg;
  logic               z_reg;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] prod_final;

  // Only SMULL takes magnitudes; MUL low bits are sign-agnostic so it stays unsigned.
  always_comb begin
    signed_op  = bus.is_long & bus.is_signed;
    a_mag      = (signed_op && bus.src_a[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.src_a) : bus.src_a;
    b_mag      = (signed_op && bus.src_b[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.src_b) : bus.src_b;
    addend     = mplier_reg[0] ? mcand_reg : {2*WIDTH{1'b0}};
    prod_final = neg_reg ? ({2*WIDTH{1'b0}} - acc_reg) : acc_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      neg_reg    <= 1'b0;
      long_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      lo_reg     <= '0;
      hi_reg     <= '0;
      n_reg      <= 1'b0;
      z_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            long_reg   <= bus.is_long;
            neg_reg    <= signed_op & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          acc_reg    <= acc_reg + addend;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH-1)) begin
            state_reg <= SIGN;
          end
        end
        SIGN: begin
          lo_reg    <= prod_final[WIDTH-1:0];
          hi_reg    <= long_reg ? prod_final[2*WIDTH-1:WIDTH] : {WIDTH{1'b0}};
          n_reg     <= long_reg ? prod_final[2*WIDTH-1] : prod_final[WIDTH-1];
          z_reg     <= long_reg ? (prod_final == {2*WIDTH{1'b0}})
                                : (prod_final[WIDTH-1:0] == {WIDTH{1'b0}});
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.result_lo = lo_reg;
  assign bus.result_hi = hi_reg;
  assign bus.flag_n    = n_reg;
  assign bus.flag_z    = z_reg;
  assign bus.mul_state = state_reg;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized and directed check of mul_sequencer against a plain-arithmetic product model.
module tb_mul_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mul_sequencer_if #(.WIDTH(32)) bus ();

  mul_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference product straight from the architectural definition.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic lng, input logic sgn,
                       output logic [31:0] lo, output logic [31:0] hi,
                       output logic n, output logic z);
    logic [63:0] p;
    longint      sp;
    if (lng && sgn) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      p  = 64'(sp);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    lo = p[31:0];
    hi = lng ? p[63:32] : 32'h0;
    n  = lng ? p[63] : p[31];
    z  = lng ? (p == 64'h0) : (p[31:0] == 32'h0);
  endtask

  // glitch: cycle in which a stray start is pulsed (0 = none); abort: cycle in which reset is asserted.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic lng, input logic sgn,
                        input int glitch, input int abort);
    logic [31:0] elo, ehi;
    logic        en, ez;
    int          busy_cnt;
    bit          seen;
    model(a, b, lng, sgn, elo, ehi, en, ez);
    @(negedge clk);
    bus.src_a = a; bus.src_b = b; bus.is_long = lng; bus.is_signed = sgn; bus.start = 1'b1;
    @(posedge clk); #1;
    busy_cnt = 0;
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (abort > 0 && c == abort + 1) begin
        check("abort_state", 64'(bus.mul_state), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_lo", 64'(bus.result_lo), 64'd0);
        check("abort_hi", 64'(bus.result_hi), 64'd0);
        check("abort_flags", {62'd0, bus.flag_n, bus.flag_z}, 64'd0);
        $display("op a=%h b=%h long=%0d signed=%0d aborted in cycle %0d", a, b, lng, sgn, abort);
        reset = 1'b1;
        return;
      end
      if (bus.busy) busy_cnt++;
      if (c == 1)  check("state_calc", 64'(bus.mul_state), 64'd1);
      if (c == 33) check("state_sign", 64'(bus.mul_state), 64'd2);
      if (bus.done) begin
        seen = 1;
        check("latency", 64'(c), 64'd34);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("result_lo", 64'(bus.result_lo), 64'(elo));
        check("result_hi", 64'(bus.result_hi), 64'(ehi));
        check("flag_n", 64'(bus.flag_n), 64'(en));
        check("flag_z", 64'(bus.flag_z), 64'(ez));
        $display("op a=%h b=%h long=%0d signed=%0d -> hi=%h lo=%h n=%0d z=%0d cycle=%0d",
                 a, b, lng, sgn, bus.result_hi, bus.result_lo, bus.flag_n, bus.flag_z, c);
      end
      bus.src_a = (c == glitch) ? 32'd9 : $urandom;
      bus.src_b = $urandom;
      bus.is_long = 1'($urandom);
      bus.is_signed = 1'($urandom);
      bus.start = (c == glitch);
      if (c == abort) reset = 1'b0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("done_pulse", 64'(bus.done), 64'd0);
    check("back_idle", 64'(bus.mul_state), 64'd0);
    check("hold_lo", 64'(bus.result_lo), 64'(elo));
    check("hold_hi", 64'(bus.result_hi), 64'(ehi));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rl, rs;
    int          g;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.is_long = 1'b0; bus.is_signed = 1'b0;
    bus.src_a = '0; bus.src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(bus.mul_state), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_lo", 64'(bus.result_lo), 64'd0);
    check("rst_hi", 64'(bus.result_hi), 64'd0);
    check("rst_flags", {62'd0, bus.flag_n, bus.flag_z}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(32'd7, 32'd6, 1'b0, 1'b0, 0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 0);
    run_op(32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 0, 0);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 0, 0);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 0, 0);
    run_op(32'h0, 32'h1234, 1'b0, 1'b0, 10, 0);
    run_op(32'hFFFFFFFD, 32'd5, 1'b0, 1'b1, 34, 0);
    run_op($urandom, $urandom, 1'b1, 1'b1, 0, 15);
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      rl = 1'($urandom); rs = 1'($urandom);
      if (i % 5 == 0) ra = {1'b1, 31'($urandom)};
      g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 34)) : 0;
      run_op(ra, rb, rl, rs, g, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Iterative 32x32 multiplier that services the multiply requests issued by the multi-cycle controller: MUL (32-bit result), UMULL and SMULL (64-bit result). The controller starts an operation with a single-cycle start pulse and stalls until done. The datapath then writes result_lo/result_hi through the normal result path. It uses a shift-add algorithm, one partial product per cycle, with sign correction for SMULL.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH.
CNT_W, 5, iteration counter width, log2(WIDTH).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  request pulse; sampled only in IDLE
is_long  input  1  1 = UMULL/SMULL (64-bit result), 0 = MUL
is_signed  input  1  1 = SMULL (two's-complement operands); ignored when is_long=0
src_a  input  WIDTH  multiplicand (Rn)
src_b  input  WIDTH  multiplier (Rm)
busy  output  1  high in CALC and SIGN
done  output  1  one-cycle pulse; results valid from this cycle on
result_lo  output  WIDTH  product bits [31:0]
result_hi  output  WIDTH  product bits [63:32] when is_long=1, else 0
flag_n  output  1  product MSB (bit 63 if long, bit 31 if short)
flag_z  output  1  1 when the product (64-bit if long, low 32 if short) is zero
mul_state  output  2  current FSM state, for debug (IDLE=0, CALC=1, SIGN=2, DONE=3)

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE; counter = 0.
  - busy, done, flag_n and flag_z = 0; result_lo and result_hi = 0.
  - Reset overrides any operation in progress, including CALC and SIGN; the partial result is discarded.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge, the block latches src_a, src_b, is_long and is_signed.
  - Operands are converted to unsigned magnitudes when is_long=1 and is_signed=1. Otherwise they are used as-is.
  - neg = a[31]^b[31] for signed; neg = 0 otherwise.
  - Accumulator cleared; counter = 0; go to CALC.
- CALC (32 cycles):
  - Each edge: if the multiplier LSB = 1, add the shifted multiplicand into the 64-bit accumulator.
  - Then shift the multiplier right 1 and the multiplicand left 1, and increment the counter.
  - When counter = WIDTH-1 at an edge, go to SIGN.
- SIGN (1 cycle):
  - If neg=1, the accumulator becomes its 64-bit two's complement.
  - Register result_lo, result_hi (forced to 0 if !is_long), flag_n and flag_z; go to DONE.
- DONE (1 cycle): done=1, busy=0; next edge goes to IDLE.
- Latency: start is sampled at the end of cycle 0; CALC occupies cycles 1..32; SIGN is cycle 33; done=1 in cycle 34.
- Input stability: inputs are sampled only at the start edge, so src_a and src_b may change afterwards without effect.
- Start outside IDLE: ignored, including in DONE. No queuing; the controller must wait for done.
- Result hold: results and flags hold their values after DONE until the next SIGN state overwrites them.
- Signed edge case: -2^31 has magnitude 0x80000000, interpreted unsigned, so SMULL(0x80000000, 0x80000000) = 0x4000000000000000.
- MUL signedness: the low 32 bits are identical for signed and unsigned operands, so is_signed has no effect when is_long=0.
- Arithmetic: the accumulator is 64-bit unsigned; no overflow is possible.

Test Plan:
1. MUL: src_a=7, src_b=6, is_long=0 -> done in cycle 34; result_lo=0x0000002A, result_hi=0, N=0, Z=0; busy high for cycles 1..33.
2. UMULL: src_a=src_b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, N=1, Z=0.
3. SMULL: src_a=0xFFFFFFFD (-3), src_b=5 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1, N=1.
4. SMULL: src_a=src_b=0x80000000 -> result_hi=0x40000000, result_lo=0, N=0, Z=0. Same operands as UMULL -> result_hi=0x40000000, result_lo=0.
5. MUL: src_a=0, src_b=0x1234 -> Z=1, N=0. Second start pulsed at cycle 10 with src_a=9 -> ignored; done only once, at cycle 34, with results unchanged.
6. reset=0 at cycle 15 of CALC -> next cycle mul_state=IDLE, busy=0, results=0. A new start with 3*4 (MUL) -> result_lo=12 after 34 cycles.
